// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - multi-digit BCD up/down timer with clamped load and wrap pulse (optional BCD_TIMER_ALARM_EN adds alarm compare)
module bcd_timer #(
   parameter int          DIGITS    = 4,
   parameter logic [31:0] DIGIT_MAX = 32'h00005959
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
`ifdef BCD_TIMER_ALARM_EN
   input  logic [4*DIGITS-1:0]   alarm_value,
   output logic                  alarm,
`endif
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic                  is_zero
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] step_count;
   logic [W-1:0] load_clamped;
   logic         step_wrap;
   logic [W-1:0] count_next;
   logic         wrap_next;

   logic         carry;
   logic [3:0]   dmax;
   logic [3:0]   dcur;
   logic [3:0]   deff;
   logic [3:0]   dnew;
   logic [3:0]   lval;

   // Ripple carry/borrow across digits; a digit above its max is treated as at max.
   always_comb begin
      step_count   = '0;
      load_clamped = '0;
      carry        = 1'b1;
      dmax         = 4'd0;
      dcur         = 4'd0;
      deff         = 4'd0;
      dnew         = 4'd0;
      lval         = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dmax = DIGIT_MAX[4*i +: 4];
         dcur = count[4*i +: 4];
         deff = (dcur > dmax) ? dmax : dcur;
         dnew = dcur;
         if (carry) begin
            if (up_down) begin
               if (deff >= dmax) begin
                  dnew = 4'd0;
               end else begin
                  dnew  = deff + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (deff == 4'd0) begin
                  dnew = dmax;
               end else begin
                  dnew  = deff - 4'd1;
                  carry = 1'b0;
               end
            end
         end
         step_count[4*i +: 4] = dnew;
         lval = load_value[4*i +: 4];
         load_clamped[4*i +: 4] = (lval > dmax) ? dmax : lval;
      end
      step_wrap = carry;
   end

   // Select next value: load beats tick beats hold; wrap only on a full-range step.
   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      if (load) begin
         count_next = load_clamped;
      end else if (tick) begin
         count_next = step_count;
         wrap_next  = step_wrap;
      end
   end

   // Count and wrap registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

`ifdef BCD_TIMER_ALARM_EN
   // Pulse when a tick or load moves the count onto the alarm value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alarm <= 1'b0;
      end else begin
         alarm <= (load || tick) && (count_next == alarm_value) && (count_next != count);
      end
   end
`endif

   assign is_zero = (count == '0);

endmodule

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
- Parametrised multi-digit BCD up/down timer.
- Generalises the single-digit cascaded counter into one block with N digits, a per-digit maximum, count direction, parallel load and a correctly timed wrap pulse.
- Used for minute:second and hour:minute reminder intervals in the water-reminder datapath.
- Driven by the shared 1 Hz tick strobe; feeds the display mux and the reminder controller.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.
- DIGIT_MAX, 32'h00005959, packed per-digit maximum, 4 bits per digit, digit 0 in bits [3:0]; each nibble 1..9; only the low 4*DIGITS bits are used.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous active-low reset
- tick  input  1  count-enable strobe, one step per cycle while high
- up_down  input  1  1 = count up, 0 = count down; sampled only when tick=1
- load  input  1  parallel load strobe
- load_value  input  4*DIGITS  BCD value to load
- count  output  4*DIGITS  current BCD value, registered
- wrap  output  1  registered one-cycle pulse on full-range wrap
- is_zero  output  1  combinational, high when count is all zero digits

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On a clk edge with reset=0: count=0, wrap=0. Reset overrides load and tick on the same edge.
- Priority per edge (reset=1): load > tick > hold.
- Load:
  - count <= load_value, with each nibble clamped to its DIGIT_MAX nibble. Nibbles above 9 are also clamped.
  - wrap <= 0.
- Tick, up:
  - Digit 0 increments.
  - A digit at its max goes to 0 and carries into the next digit. Ripple is combinational within the same cycle.
  - All digits at max -> all zero, and wrap <= 1 on the same edge.
- Tick, down:
  - Digit 0 decrements.
  - A digit at 0 goes to its max and borrows from the next digit.
  - All digits zero -> all digits at max, and wrap <= 1 on the same edge.
- Hold: tick=0 and load=0 -> count unchanged, wrap <= 0.
- wrap timing:
  - High in exactly the cycle in which count shows the wrapped value, never one step early.
  - Consecutive ticks across two wraps give two separate one-cycle pulses.
- Latency: count and wrap update on the edge after the sampled inputs; is_zero follows count with no added latency.
- Direction change: applies at the next tick. No internal state beyond count and wrap.
- Out-of-range state: unreachable by construction. If forced, a digit above its max is treated as at max.

Optional Feature:
- Macro: BCD_TIMER_ALARM_EN.
- Defined:
  - Adds input alarm_value (4*DIGITS) and output alarm (1).
  - alarm is a registered one-cycle pulse, asserted in the cycle in which count first equals alarm_value after a tick or load.
  - Holding at a matching value does not re-pulse.
  - Reset clears alarm.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: drive reset=0 one edge with load=1 and tick=1 -> count=16'h0000, wrap=0, is_zero=1.
- Up carry chain (DIGITS=4, DIGIT_MAX=16'h5959): load 16'h0959, then tick up once -> count=16'h1000, wrap=0.
- Up wrap: load 16'h5958, tick up twice -> count 16'h5959 with wrap=0, then 16'h0000 with wrap=1 in that same cycle; next idle cycle wrap=0.
- Down wrap: load 16'h0001, tick down twice -> 16'h0000 with is_zero=1, then 16'h5959 with wrap=1.
- Load clamp and priority: load=1, tick=1, load_value=16'h7A3C -> count=16'h5939, wrap=0.
- Alarm (macro defined): alarm_value=16'h0003, load 16'h0000, tick up 3 -> alarm=1 only in the cycle count becomes 16'h0003; hold 5 cycles -> alarm stays 0.
